enc_lane_scheduler: RTL and testbench

Per-symbol source scheduler in front of the dual-lane encoding block. Arbitrates between the ordered-set generator and the transport-layer byte stream, and locks one source for a whole symbol window (16 bytes Gen3, 8 bytes Gen2, 1 byte Gen4). Drives lane bytes, `d_sel`, `enable` and `gen_speed` to the encoder.

---
 rtl/enc_lane_scheduler_pkg.sv | 14 +
 rtl/enc_lane_scheduler_if.sv | 33 +++
 rtl/enc_lane_scheduler_sym_counter.sv | 39 +++
 rtl/enc_lane_scheduler.sv | 84 ++++++++
 tb/tb_enc_lane_scheduler.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/enc_lane_scheduler_pkg.sv
// enc_sched_pkg: shared constants, state encoding and symbol-length helper for the lane scheduler
package enc_sched_pkg;
    localparam logic [3:0] D_SEL_TL   = 4'd8;
    localparam logic [3:0] D_SEL_IDLE = 4'd9;
    localparam logic [1:0] GEN4       = 2'd0;
    localparam logic [1:0] GEN3       = 2'd1;
    localparam logic [1:0] GEN2       = 2'd2;

    typedef enum logic [1:0] {ST_IDLE, ST_OS, ST_TL} state_t;

    function automatic logic [4:0] sym_len(input logic [1:0] speed);
        return speed == GEN4 ? 5'd1 : speed == GEN3 ? 5'd16 : 5'd8;
    endfunction
endpackage

// File: rtl/enc_lane_scheduler_if.sv
// enc_lane_scheduler_if: source handshakes plus encoder-facing outputs of the lane scheduler
interface enc_lane_scheduler_if;
    logic       link_en;
    logic [1:0] gen_speed_in;
    logic       os_req;
    logic [3:0] os_type;
    logic [7:0] os_byte_0, os_byte_1;
    logic       os_ack;
    logic       tl_valid;
    logic [7:0] tl_byte_0, tl_byte_1;
    logic       tl_ready;
    logic [7:0] lane_0_tx, lane_1_tx;
    logic [3:0] d_sel;
    logic       enc_enable;
    logic [1:0] gen_speed;
    logic       sym_start;
    logic       tl_underrun;
    logic       type_err;

    modport slave (
        input  link_en, gen_speed_in, os_req, os_type, os_byte_0, os_byte_1,
               tl_valid, tl_byte_0, tl_byte_1,
        output os_ack, tl_ready, lane_0_tx, lane_1_tx, d_sel, enc_enable,
               gen_speed, sym_start, tl_underrun, type_err
    );

    modport master (
        output link_en, gen_speed_in, os_req, os_type, os_byte_0, os_byte_1,
               tl_valid, tl_byte_0, tl_byte_1,
        input  os_ack, tl_ready, lane_0_tx, lane_1_tx, d_sel, enc_enable,
               gen_speed, sym_start, tl_underrun, type_err
    );
endinterface

// File: rtl/enc_lane_scheduler_sym_counter.sv
// enc_sym_counter: byte index of the symbol currently on the lanes, with the speed latched at its start
module enc_sym_counter
    import enc_sched_pkg::*;
(
    input  logic       enc_clk,
    input  logic       rst,
    input  logic       i_clr,
    input  logic       i_idle,
    input  logic [1:0] i_speed,
    output logic [3:0] o_cnt,
    output logic [1:0] o_spd,
    output logic       o_boundary,
    output logic       o_first
);
    logic [3:0] r_cnt;
    logic [1:0] r_spd;
    logic       w_boundary;

    assign w_boundary = i_idle || ({1'b0, r_cnt} == sym_len(r_spd) - 5'd1);

    always_ff @(posedge enc_clk or posedge rst)
        if (rst) begin
            r_cnt <= '0;
            r_spd <= GEN4;
        end else if (i_clr) begin
            r_cnt <= '0;
            r_spd <= GEN4;
        end else if (w_boundary) begin
            r_cnt <= '0;
            r_spd <= (i_speed == 2'd3) ? GEN2 : i_speed;
        end else begin
            r_cnt <= r_cnt + 4'd1;
        end

    assign o_cnt      = r_cnt;
    assign o_spd      = r_spd;
    assign o_boundary = w_boundary;
    assign o_first    = !i_idle && r_cnt == 4'd0;
endmodule

// File: rtl/enc_lane_scheduler.sv
// enc_lane_scheduler: per-symbol arbiter between ordered-set and transport sources feeding the dual-lane encoder
module enc_lane_scheduler
    import enc_sched_pkg::*;
#(
    parameter int FAIR_LIMIT = 4
) (
    input logic                 enc_clk,
    input logic                 rst,
    enc_lane_scheduler_if.slave bus
);
    localparam int FW = $clog2(FAIR_LIMIT + 1);

    state_t        r_state, w_next;
    logic [FW-1:0] r_fair;
    logic [7:0]    r_lane_0, r_lane_1;
    logic [3:0]    r_d_sel;
    logic          r_enable, r_underrun, r_type_err;
    logic [3:0]    w_cnt;
    logic [1:0]    w_spd;
    logic          w_boundary, w_first, w_fair_full;
    logic          w_grant_os, w_grant_tl, w_take_os, w_take_tl;

    enc_sym_counter u_cnt (
        .enc_clk   (enc_clk),
        .rst       (rst),
        .i_clr     (!bus.link_en),
        .i_idle    (r_state == ST_IDLE),
        .i_speed   (bus.gen_speed_in),
        .o_cnt     (w_cnt),
        .o_spd     (w_spd),
        .o_boundary(w_boundary),
        .o_first   (w_first)
    );

    // At a boundary the bytes consumed are byte 0 of the next symbol, so ack/ready decode the new grant
    always_comb begin
        w_fair_full = r_fair == FW'(FAIR_LIMIT);
        w_grant_os  = w_boundary && bus.os_req && !(w_fair_full && bus.tl_valid);
        w_grant_tl  = w_boundary && !w_grant_os && bus.tl_valid;
        w_take_os   = w_grant_os || (!w_boundary && r_state == ST_OS);
        w_take_tl   = w_grant_tl || (!w_boundary && r_state == ST_TL && bus.tl_valid);
        w_next      = !bus.link_en ? ST_IDLE :
                      !w_boundary  ? r_state :
                      w_grant_os   ? ST_OS   :
                      w_grant_tl   ? ST_TL   : ST_IDLE;
    end

    always_ff @(posedge enc_clk or posedge rst)
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;

    always_ff @(posedge enc_clk or posedge rst)
        if (rst || !bus.link_en) begin
            r_fair     <= '0;
            r_lane_0   <= 8'h00;
            r_lane_1   <= 8'h00;
            r_d_sel    <= D_SEL_IDLE;
            r_enable   <= 1'b0;
            r_underrun <= 1'b0;
            r_type_err <= 1'b0;
        end else begin
            r_fair     <= w_grant_tl ? '0 :
                          (w_grant_os && bus.tl_valid && !w_fair_full) ? r_fair + FW'(1) : r_fair;
            r_lane_0   <= w_take_os ? bus.os_byte_0 : w_take_tl ? bus.tl_byte_0 : 8'h00;
            r_lane_1   <= w_take_os ? bus.os_byte_1 : w_take_tl ? bus.tl_byte_1 : 8'h00;
            r_d_sel    <= !w_boundary ? r_d_sel :
                          w_grant_os  ? (bus.os_type > 4'd7 ? 4'd0 : bus.os_type) :
                          w_grant_tl  ? D_SEL_TL : D_SEL_IDLE;
            r_enable   <= 1'b1;
            r_underrun <= !w_boundary && r_state == ST_TL && !bus.tl_valid;
            r_type_err <= w_grant_os && bus.os_type > 4'd7;
        end

    assign bus.os_ack      = bus.link_en && !rst && w_take_os;
    assign bus.tl_ready    = bus.link_en && !rst && w_take_tl;
    assign bus.lane_0_tx   = r_lane_0;
    assign bus.lane_1_tx   = r_lane_1;
    assign bus.d_sel       = r_d_sel;
    assign bus.enc_enable  = r_enable;
    assign bus.gen_speed   = w_spd;
    assign bus.sym_start   = w_first;
    assign bus.tl_underrun = r_underrun;
    assign bus.type_err    = r_type_err;
endmodule

// File: tb/tb_enc_lane_scheduler.sv
// tb_enc_lane_scheduler: directed checks of arbitration, fairness, underrun, speed latching and reset/clear
module tb_enc_lane_scheduler;
    import enc_sched_pkg::*;

    logic enc_clk = 1'b0;
    logic rst     = 1'b1;
    int   n_checks = 0;
    int   n_err    = 0;

    enc_lane_scheduler_if bus();

    enc_lane_scheduler #(.FAIR_LIMIT(4)) dut (
        .enc_clk(enc_clk),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 enc_clk = ~enc_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge enc_clk);
        #1;
    endtask

    initial begin
        bus.link_en = 1'b1; bus.gen_speed_in = GEN3;
        bus.os_req = 1'b1; bus.os_type = 4'd5; bus.os_byte_0 = 8'h00; bus.os_byte_1 = 8'h00;
        bus.tl_valid = 1'b0; bus.tl_byte_0 = 8'h00; bus.tl_byte_1 = 8'h00;
        tick(); tick();
        chk("rst_lane0", bus.lane_0_tx, 0);
        chk("rst_lane1", bus.lane_1_tx, 0);
        chk("rst_dsel", bus.d_sel, 9);
        chk("rst_enable", bus.enc_enable, 0);
        chk("rst_speed", bus.gen_speed, 0);
        chk("rst_start", bus.sym_start, 0);
        chk("rst_ack", bus.os_ack, 0);
        chk("rst_ready", bus.tl_ready, 0);
        chk("rst_under", bus.tl_underrun, 0);
        chk("rst_terr", bus.type_err, 0);
        rst = 1'b0;
        // Gen3 ordered-set symbol, type 5, bytes 0x10..0x1F
        for (int i = 0; i < 16; i++) begin
            bus.os_byte_0 = 8'(8'h10 + i); bus.os_byte_1 = 8'(8'h90 + i);
            #1 chk("os1_ack", bus.os_ack, 1);
            tick();
            chk("os1_lane0", bus.lane_0_tx, 32'h10 + i);
            chk("os1_lane1", bus.lane_1_tx, 32'h90 + i);
            chk("os1_dsel", bus.d_sel, 5);
            chk("os1_start", bus.sym_start, i == 0);
            chk("os1_speed", bus.gen_speed, 1);
            chk("os1_enable", bus.enc_enable, 1);
        end
        bus.os_req = 1'b0;
        #1 chk("idle_ack", bus.os_ack, 0);
        tick();
        chk("idle_dsel", bus.d_sel, 9);
        chk("idle_lane0", bus.lane_0_tx, 0);
        chk("idle_enable", bus.enc_enable, 1);
        chk("idle_start", bus.sym_start, 0);
        // Gen2 transport back-to-back, valid dropped at byte 3 of the third symbol
        bus.gen_speed_in = GEN2;
        for (int i = 0; i < 24; i++) begin
            bus.tl_valid = (i != 19); bus.tl_byte_0 = 8'(i + 1); bus.tl_byte_1 = 8'(i + 8'h41);
            #1 chk("tl_ready", bus.tl_ready, i != 19);
            tick();
            chk("tl_lane0", bus.lane_0_tx, (i != 19) ? i + 1 : 0);
            chk("tl_lane1", bus.lane_1_tx, (i != 19) ? i + 8'h41 : 0);
            chk("tl_dsel", bus.d_sel, 8);
            chk("tl_start", bus.sym_start, i % 8 == 0);
            chk("tl_under", bus.tl_underrun, i == 19);
            chk("tl_speed", bus.gen_speed, 2);
        end
        // Gen3 fairness: four OS symbols, one forced TL, then OS
        bus.gen_speed_in = GEN3; bus.os_req = 1'b1; bus.os_type = 4'd3; bus.tl_valid = 1'b1;
        bus.os_byte_0 = 8'hA5; bus.tl_byte_0 = 8'h5A;
        for (int s = 0; s < 6; s++)
            for (int b = 0; b < 16; b++) begin
                #1 chk("fair_ack", bus.os_ack, s != 4);
                chk("fair_ready", bus.tl_ready, s == 4);
                tick();
                chk("fair_dsel", bus.d_sel, (s == 4) ? 8 : 3);
                chk("fair_lane0", bus.lane_0_tx, (s == 4) ? 8'h5A : 8'hA5);
                chk("fair_start", bus.sym_start, b == 0);
            end
        // speed change mid-symbol only lands at the next boundary
        bus.tl_valid = 1'b0;
        for (int b = 0; b < 16; b++) begin
            if (b == 5) bus.gen_speed_in = GEN2;
            #1 chk("spd_ack", bus.os_ack, 1);
            tick();
            chk("spd_g3_speed", bus.gen_speed, 1);
            chk("spd_g3_start", bus.sym_start, b == 0);
        end
        for (int b = 0; b < 8; b++) begin
            tick();
            chk("spd_g2_speed", bus.gen_speed, 2);
            chk("spd_g2_start", bus.sym_start, b == 0);
        end
        bus.gen_speed_in = GEN3; bus.os_type = 4'd6;
        for (int b = 0; b < 8; b++) begin
            bus.os_byte_0 = 8'(8'h30 + b);
            tick();
            chk("pre_start", bus.sym_start, b == 0);
            chk("pre_lane0", bus.lane_0_tx, 32'h30 + b);
            chk("pre_speed", bus.gen_speed, 1);
            chk("pre_dsel", bus.d_sel, 6);
        end
        // async reset at byte 7 of a Gen3 OS symbol
        rst = 1'b1;
        #1;
        chk("arst_lane0", bus.lane_0_tx, 0);
        chk("arst_dsel", bus.d_sel, 9);
        chk("arst_enable", bus.enc_enable, 0);
        chk("arst_speed", bus.gen_speed, 0);
        chk("arst_start", bus.sym_start, 0);
        chk("arst_ack", bus.os_ack, 0);
        tick();
        rst = 1'b0;
        for (int b = 0; b < 8; b++) begin
            bus.os_byte_0 = 8'(8'h50 + b);
            #1 chk("post_ack", bus.os_ack, 1);
            tick();
            chk("post_start", bus.sym_start, b == 0);
            chk("post_lane0", bus.lane_0_tx, 32'h50 + b);
            chk("post_dsel", bus.d_sel, 6);
            chk("post_speed", bus.gen_speed, 1);
        end
        // link_en low clears on the following edge
        bus.link_en = 1'b0;
        #1 chk("len_ack", bus.os_ack, 0);
        chk("len_hold_lane0", bus.lane_0_tx, 8'h57);
        tick();
        chk("len_lane0", bus.lane_0_tx, 0);
        chk("len_dsel", bus.d_sel, 9);
        chk("len_enable", bus.enc_enable, 0);
        chk("len_speed", bus.gen_speed, 0);
        chk("len_start", bus.sym_start, 0);
        bus.link_en = 1'b1; bus.os_type = 4'hC; bus.os_byte_0 = 8'h50;
        #1 chk("len2_ack", bus.os_ack, 1);
        tick();
        chk("len2_start", bus.sym_start, 1);
        chk("len2_lane0", bus.lane_0_tx, 8'h50);
        chk("terr_dsel", bus.d_sel, 0);
        chk("terr_pulse", bus.type_err, 1);
        chk("len2_speed", bus.gen_speed, 1);
        bus.os_byte_0 = 8'h51;
        tick();
        chk("terr_clear", bus.type_err, 0);
        chk("len2_start1", bus.sym_start, 0);
        chk("len2_lane0_1", bus.lane_0_tx, 8'h51);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
